nonce_dispatcher: RTL and testbench

- Parametrised successor to the single-counter nonce generator.
- Owns one nonce range [range_start, range_end] and hands nonces, stepping by STEP, to NUM_CORES hash cores.
- Uses level request / one-cycle grant with round-robin fairness.
- Sits between the miner control FSM (load/start/restart) and the parallel SHA cores; signals done when the range is exhausted.

---
 rtl/nonce_dispatcher.sv | 227 ++++++++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// nonce_dispatcher
//
// Purpose:
//   Owns one nonce range [range_start, range_end] and hands out nonces,
//   stepping by STEP, to NUM_CORES hash cores. Cores raise a level request.
//   Each issued nonce is announced by a one-cycle, one-hot, registered grant.
//   Grants rotate round-robin among the requesters. done is raised once the
//   range is exhausted.
//
// Parameters:
//   WIDTH      nonce width in bits
//   NUM_CORES  number of requesting cores (>= 1)
//   STEP       increment between successive issued nonces (>= 1)
//   START_VAL  reset value of the range start and of the next nonce
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active-high
//   load             latch range_start_in / range_end_in, go to IDLE
//   range_start_in   first nonce of the new range
//   range_end_in     last permitted nonce (inclusive)
//   start            IDLE -> RUN (or DONE for an empty range)
//   restart          rewind next nonce to the latched range start, go to IDLE
//   enable           0 = hold; only load, restart and rst act
//   req              level request, one bit per core
//   grant            one-hot registered grant, one cycle per issued nonce
//   nonce_out        issued nonce, valid while grant != 0, holds otherwise
//   done             high while in DONE
//   issued_count     nonces issued since the last load/restart (never wraps)
//
// Optional feature (macro NONCE_SNAPSHOT_EN):
//   snap        capture the post-update next nonce into snap_nonce
//   resume      in IDLE, reload the next nonce from snap_nonce
//   snap_nonce  captured lowest unissued nonce
// -----------------------------------------------------------------------------
module nonce_dispatcher #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_CORES = 4,
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1),
  parameter logic [WIDTH-1:0] START_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     range_start_in,
  input  logic [WIDTH-1:0]     range_end_in,
  input  logic                 start,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [NUM_CORES-1:0] req,
`ifdef NONCE_SNAPSHOT_EN
  input  logic                 snap,
  input  logic                 resume,
  output logic [WIDTH-1:0]     snap_nonce,
`endif
  output logic [NUM_CORES-1:0] grant,
  output logic [WIDTH-1:0]     nonce_out,
  output logic                 done,
  output logic [WIDTH:0]       issued_count
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     start_q, start_d;
  logic [WIDTH-1:0]     end_q, end_d;
  logic [WIDTH-1:0]     next_q, next_d;
  logic [WIDTH-1:0]     nonce_q, nonce_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       issued_q, issued_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  // Requests are registered first, so a request seen at one edge produces
  // its grant after the following edge.
  logic [NUM_CORES-1:0] req_q;
`ifdef NONCE_SNAPSHOT_EN
  logic [WIDTH-1:0]     snap_q, snap_d;
`endif

  // Round-robin search over the registered requests, starting at rr_q
  // (the core after the last one granted).
  logic             found;
  logic [PTR_W-1:0] pick;
  int               idx;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(rr_q) + i) % NUM_CORES;
      if (!found && req_q[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // Exhaustion test done one bit wider so that a carry out of the nonce
  // width ends the range instead of wrapping back to low nonces.
  logic [WIDTH:0] sum;
  logic           last_issue;

  always_comb begin
    sum        = {1'b0, next_q} + {1'b0, STEP};
    last_issue = sum[WIDTH] || (sum > {1'b0, end_q});
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    next_d   = next_q;
    nonce_d  = nonce_q;
    grant_d  = '0;
    issued_d = issued_q;
    rr_d     = rr_q;
`ifdef NONCE_SNAPSHOT_EN
    snap_d   = snap_q;
`endif

    if (load) begin
      state_d  = S_IDLE;
      start_d  = range_start_in;
      end_d    = range_end_in;
      next_d   = range_start_in;
      issued_d = '0;
    end else if (restart) begin
      state_d  = S_IDLE;
      next_d   = start_q;
      issued_d = '0;
    end else if (enable) begin
      unique case (state_q)
        S_IDLE: begin
`ifdef NONCE_SNAPSHOT_EN
          if (resume) begin
            next_d = snap_q;
          end else
`endif
          if (start) begin
            state_d = (start_q > end_q) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (found) begin
            for (int i = 0; i < NUM_CORES; i++) begin
              grant_d[i] = (PTR_W'(i) == pick);
            end
            nonce_d  = next_q;
            next_d   = sum[WIDTH-1:0];
            issued_d = issued_q + 1'b1;
            rr_d     = (pick == PTR_W'(NUM_CORES - 1)) ? '0 : pick + 1'b1;
            if (last_issue) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Requests are ignored until load or restart.
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef NONCE_SNAPSHOT_EN
    // Capture after this cycle's update so a same-cycle issue is excluded
    // from the snapshot: snap_nonce is always the lowest unissued nonce.
    if (enable && snap) begin
      snap_d = next_d;
    end
`endif

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= START_VAL;
      end_q    <= '1;
      next_q   <= START_VAL;
      nonce_q  <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      issued_q <= '0;
      rr_q     <= '0;
      req_q    <= '0;
`ifdef NONCE_SNAPSHOT_EN
      snap_q   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its _d value from before this edge, independent of order.
      state_q  <= state_d;
      start_q  <= start_d;
      end_q    <= end_d;
      next_q   <= next_d;
      nonce_q  <= nonce_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      issued_q <= issued_d;
      rr_q     <= rr_d;
      req_q    <= req;
`ifdef NONCE_SNAPSHOT_EN
      snap_q   <= snap_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign nonce_out    = nonce_q;
  assign done         = done_q;
  assign issued_count = issued_q;
`ifdef NONCE_SNAPSHOT_EN
  assign snap_nonce   = snap_q;
`endif

endmodule

// File: tb/tb_nonce_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_nonce_dispatcher
//
// Two dispatchers (STEP=1 and STEP=3) share one stimulus stream. A reference
// model per instance predicts every issued nonce (pushed into an issue queue)
// and the per-cycle status (done, issued_count, nonce_out). A monitor at the
// falling clock edge pops and compares. Directed sequences come first, then
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_nonce_dispatcher;

  localparam longint MASK = 64'hFFFF_FFFF;

  typedef struct {
    int     core;
    longint nonce;
  } issue_t;

  typedef struct {
    bit     done;
    longint issued;
    longint nonce;
  } stat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        enable = 1'b1;
  logic        snap = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] rs = '0;
  logic [31:0] re = '0;
  logic [3:0]  req = '0;

  logic [3:0]  grant_w [2];
  logic [31:0] nonce_w [2];
  logic        done_w  [2];
  logic [32:0] cnt_w   [2];
`ifdef NONCE_SNAPSHOT_EN
  logic [31:0] snapn_w [2];
`endif

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  nonce_dispatcher #(.WIDTH(32), .NUM_CORES(4), .STEP(32'd1), .START_VAL(32'd0)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .range_start_in(rs), .range_end_in(re),
    .start(start), .restart(restart), .enable(enable), .req(req),
`ifdef NONCE_SNAPSHOT_EN
    .snap(snap), .resume(resume), .snap_nonce(snapn_w[0]),
`endif
    .grant(grant_w[0]), .nonce_out(nonce_w[0]), .done(done_w[0]), .issued_count(cnt_w[0])
  );

  nonce_dispatcher #(.WIDTH(32), .NUM_CORES(4), .STEP(32'd3), .START_VAL(32'd0)) u_dut3 (
    .clk(clk), .rst(rst), .load(load), .range_start_in(rs), .range_end_in(re),
    .start(start), .restart(restart), .enable(enable), .req(req),
`ifdef NONCE_SNAPSHOT_EN
    .snap(snap), .resume(resume), .snap_nonce(snapn_w[1]),
`endif
    .grant(grant_w[1]), .nonce_out(nonce_w[1]), .done(done_w[1]), .issued_count(cnt_w[1])
  );

  // ---------------------------------------------------------------- model --
  longint     stepv [2] = '{1, 3};
  int         m_mode [2];   // 0 idle, 1 run, 2 done
  longint     m_start [2], m_end [2], m_next [2], m_issued [2], m_nonce [2], m_snap [2];
  int         m_last [2];   // last granted core, -1 after reset
  logic [3:0] m_reqp [2];   // request value seen at the previous edge

  issue_t iq0[$], iq1[$];
  stat_t  sq0[$], sq1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of the coming rising edge for instance d.
  task automatic model_step(input int d);
    issue_t it;
    stat_t  st;
    int     k;
    int     c;
    if (rst) begin
      m_mode[d] = 0; m_start[d] = 0; m_end[d] = MASK; m_next[d] = 0;
      m_issued[d] = 0; m_nonce[d] = 0; m_last[d] = -1; m_reqp[d] = '0; m_snap[d] = 0;
    end else begin
      if (load) begin
        m_mode[d] = 0; m_start[d] = rs; m_end[d] = re; m_next[d] = rs; m_issued[d] = 0;
      end else if (restart) begin
        m_mode[d] = 0; m_next[d] = m_start[d]; m_issued[d] = 0;
      end else if (enable) begin
        if (m_mode[d] == 0) begin
          if (resume) m_next[d] = m_snap[d];
          else if (start) m_mode[d] = (m_start[d] > m_end[d]) ? 2 : 1;
        end else if (m_mode[d] == 1 && m_reqp[d] != 0) begin
          k = -1;
          for (int i = 1; i <= 4; i++) begin
            c = (m_last[d] + i) % 4;
            if (k < 0 && m_reqp[d][c]) k = c;
          end
          it.core = k; it.nonce = m_next[d];
          if (d == 0) iq0.push_back(it); else iq1.push_back(it);
          m_nonce[d] = m_next[d];
          m_issued[d]++;
          m_last[d] = k;
          if (m_next[d] + stepv[d] > m_end[d]) m_mode[d] = 2;
          m_next[d] = (m_next[d] + stepv[d]) & MASK;
        end
      end
      if (enable && snap) m_snap[d] = m_next[d];
      m_reqp[d] = req;
    end
    st.done = (m_mode[d] == 2); st.issued = m_issued[d]; st.nonce = m_nonce[d];
    if (d == 0) sq0.push_back(st); else sq1.push_back(st);
  endtask

  // -------------------------------------------------------------- monitor --
  task automatic mon(input int d);
    stat_t      st;
    issue_t     it;
    logic [3:0] eg;
    bit         have_st;
    bit         have_it;
    have_st = (d == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
    if (have_st) begin
      if (d == 0) st = sq0.pop_front(); else st = sq1.pop_front();
      check($sformatf("done[%0d]", d), 64'(done_w[d]), 64'(st.done));
      check($sformatf("issued_count[%0d]", d), 64'(cnt_w[d]), st.issued);
      check($sformatf("nonce_out[%0d]", d), 64'(nonce_w[d]), st.nonce);
    end
    if (grant_w[d] != 0) begin
      have_it = (d == 0) ? (iq0.size() > 0) : (iq1.size() > 0);
      if (!have_it) begin
        check($sformatf("unexpected_grant[%0d]", d), 64'(grant_w[d]), 64'd0);
      end else begin
        if (d == 0) it = iq0.pop_front(); else it = iq1.pop_front();
        eg = 4'b0001 << it.core;
        check($sformatf("grant[%0d]", d), 64'(grant_w[d]), 64'(eg));
        check($sformatf("grant_nonce[%0d]", d), 64'(nonce_w[d]), it.nonce);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // ------------------------------------------------------------ stimulus --
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  // Reset is raised only after the monitor has consumed the previous edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_ctl();
    load = 1'b0; start = 1'b0; restart = 1'b0; snap = 1'b0; resume = 1'b0; enable = 1'b1;
  endtask

  task automatic load_range(input logic [31:0] s, input logic [31:0] e);
    load = 1'b1; rs = s; re = e;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s, e;
    // Reset state.
    step();
    step();
    rst = 1'b0;
    check("rst_grant", 64'(grant_w[0]), 64'd0);
    check("rst_done", 64'(done_w[0]), 64'd0);
    check("rst_count", 64'(cnt_w[0]), 64'd0);

    // Range 5..9, one steady requester.
    req = 4'b0001;
    load_range(32'd5, 32'd9);
    do_start();
    repeat (5) step();
    check("t1_done", 64'(done_w[0]), 64'd1);
    check("t1_count", 64'(cnt_w[0]), 64'd5);
    check("t1_last_nonce", 64'(nonce_w[0]), 64'd9);
    check("t1_step3_count", 64'(cnt_w[1]), 64'd2);
    repeat (2) step();

    // Round-robin over all cores, then core 1 drops out.
    do_reset();
    req = 4'b1111;
    load_range(32'd0, 32'd99);
    do_start();
    repeat (5) step();
    req = 4'b1101;
    repeat (8) step();

    // Range at the top of the nonce space: carry ends the range.
    load_range(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    do_start();
    repeat (20) step();
    check("t3_count_step1", 64'(cnt_w[0]), 64'd16);
    check("t3_count_step3", 64'(cnt_w[1]), 64'd6);
    check("t3_nonce_step3", 64'(nonce_w[1]), 64'hFFFF_FFFF);
    check("t3_done_step3", 64'(done_w[1]), 64'd1);

    // Empty range.
    load_range(32'd10, 32'd4);
    do_start();
    check("t4_done", 64'(done_w[0]), 64'd1);
    check("t4_count", 64'(cnt_w[0]), 64'd0);
    repeat (2) step();

    // Hold with enable=0, then restart, then load+restart together.
    req = 4'b0001;
    load_range(32'd0, 32'd1000);
    do_start();
    repeat (20) step();
    enable = 1'b0;
    repeat (3) step();
    check("t5_hold_count", 64'(cnt_w[0]), 64'd20);
    enable = 1'b1;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t5_restart_count", 64'(cnt_w[0]), 64'd0);
    load = 1'b1; restart = 1'b1; rs = 32'd200; re = 32'd210;
    step();
    clear_ctl();
    do_start();
    repeat (14) step();
    check("t5_newrange_count", 64'(cnt_w[0]), 64'd11);
    check("t5_newrange_last", 64'(nonce_w[0]), 64'd210);

`ifdef NONCE_SNAPSHOT_EN
    // Snapshot after 50 issues, then resume from it.
    do_reset();
    req = 4'b0001;
    load_range(32'd0, 32'd1000);
    do_start();
    repeat (49) step();
    snap = 1'b1;
    step();
    snap = 1'b0;
    check("snap_nonce", 64'(snapn_w[0]), 64'd50);
    req = 4'b0000;
    restart = 1'b1;
    step();
    restart = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    req = 4'b0001;
    do_start();
    repeat (3) step();
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      clear_ctl();
      req    = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        load = 1'b1;
        case ($urandom_range(0, 3))
          0: s = longint'(MASK) - longint'($urandom_range(0, 40));
          1: s = longint'($urandom_range(0, 100));
          default: s = longint'($urandom);
        endcase
        if ($urandom_range(0, 7) == 0) e = s - longint'($urandom_range(1, 5));
        else e = s + longint'($urandom_range(0, 60));
        if (e > MASK) e = MASK;
        if (e < 0) e = 0;
        rs = 32'(s);
        re = 32'(e);
      end
      restart = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 5) == 0);
`ifdef NONCE_SNAPSHOT_EN
      snap    = ($urandom_range(0, 19) == 0);
      resume  = ($urandom_range(0, 29) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        clear_ctl();
        do_reset();
      end else begin
        step();
      end
    end

    clear_ctl();
    req = 4'b0000;
    repeat (4) step();
    check("issue_queue0_drained", 64'(iq0.size()), 64'd0);
    check("issue_queue1_drained", 64'(iq1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
